// File: rtl/isa_dma_sequencer.sv
// isa_dma_sequencer
//   ISA single-mode DMA sequencer for the sound card. Two requesters (8-bit
//   and 16-bit sound DMA engines) share the on-card DRQ triggers. At most one
//   request is outstanding. Each transfer ends in a one-cycle ack strobe, with
//   the bus data captured into rdata.
//   Optional build macro: ISA_DMA_RECORD_EN adds the card-to-host (IOR) path.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req8, req16             level requests from the sound DMA engines
//   dack8_n, dack16_n       ISA DACKs (async, active-low)
//   iow_n, ior_n, aen, tc   ISA strobes (async)
//   sd_in                   ISA data bus, input side
//   wdata/sd_out/sd_oe      record data path (ISA_DMA_RECORD_EN only)
//   drq_lo_trig_n           low asserts the 8-bit DRQ pin
//   drq_hi_trig_n           low asserts the 16-bit DRQ pin
//   ack8, ack16             one-cycle transfer-complete strobes
//   rdata                   bus data of the last IOW transfer
//   tc_pulse                TC seen with the ack strobe
//   timeout                 one-cycle pulse when DRQ is withdrawn after timeout
//   busy                    FSM not idle
module isa_dma_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req8,
    input  logic        req16,
    input  logic        dack8_n,
    input  logic        dack16_n,
    input  logic        iow_n,
    input  logic        ior_n,
    input  logic        aen,
    input  logic        tc,
    input  logic [15:0] sd_in,
`ifdef ISA_DMA_RECORD_EN
    input  logic [15:0] wdata,
    output logic [15:0] sd_out,
    output logic        sd_oe,
`endif
    output logic        drq_lo_trig_n,
    output logic        drq_hi_trig_n,
    output logic        ack8,
    output logic        ack16,
    output logic [15:0] rdata,
    output logic        tc_pulse,
    output logic        timeout,
    output logic        busy
);
    localparam int unsigned SYNC_W = 6;
    // {tc, aen, ior_n, iow_n, dack16_n, dack8_n} at their inactive levels
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 6'b00_1111;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_t;

    logic [SYNC_W-1:0] sync_meta, sync_s;
    logic              dack8_s, dack16_s, iow_s, ior_s, aen_s, tc_s;
    logic              iow_d, iow_rise;
    logic [15:0]       sd_hold;

    state_t            state, state_nx;
    logic              grant, grant_nx, last_grant, last_grant_nx;
    logic [TO_W-1:0]   cnt, cnt_nx;
    logic              trig_g_nx, ack_nx, tc_nx, timeout_nx, rdata_load;
    logic              g_req, g_dack_n, g_trig_n;

`ifdef ISA_DMA_RECORD_EN
    logic              ior_d, ior_rise, sd_oe_nx;
`else
    logic              unused_ior;
    assign unused_ior = ior_s;
`endif

    // Two-flop synchronisers for all asynchronous ISA handshake inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= SYNC_IDLE;
            sync_s    <= SYNC_IDLE;
        end else begin
            sync_meta <= {tc, aen, ior_n, iow_n, dack16_n, dack8_n};
            sync_s    <= sync_meta;
        end
    end

    assign {tc_s, aen_s, ior_s, iow_s, dack16_s, dack8_s} = sync_s;

    // Edge-detect flops and the bus data holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iow_d   <= 1'b1;
            sd_hold <= '0;
        end else begin
            iow_d <= iow_s;
            if (!iow_s) sd_hold <= sd_in;
        end
    end
    assign iow_rise = iow_s & ~iow_d;

`ifdef ISA_DMA_RECORD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ior_d <= 1'b1;
        else        ior_d <= ior_s;
    end
    assign ior_rise = ior_s & ~ior_d;
`endif

    // Signals of the currently granted channel
    assign g_req    = grant ? req16         : req8;
    assign g_dack_n = grant ? dack16_s      : dack8_s;
    assign g_trig_n = grant ? drq_hi_trig_n : drq_lo_trig_n;

    // Next-state and next-output logic
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        trig_g_nx     = 1'b1;
        ack_nx        = 1'b0;
        tc_nx         = 1'b0;
        timeout_nx    = 1'b0;
        rdata_load    = 1'b0;
`ifdef ISA_DMA_RECORD_EN
        sd_oe_nx      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req8 || req16) begin
                    // Round robin only matters when both are requesting
                    grant_nx  = (req8 && req16) ? ~last_grant : req16;
                    cnt_nx    = '0;
                    trig_g_nx = 1'b0;
                    state_nx  = REQ;
                end
            end
            REQ: begin
                if (!g_dack_n && aen_s) begin
                    trig_g_nx = 1'b0;
                    state_nx  = XFER;
                end else if (!g_req) begin
                    state_nx = IDLE;
                end else if (cnt == TO_LAST) begin
                    // Hand priority to the other channel so it is not starved
                    timeout_nx    = 1'b1;
                    last_grant_nx = grant;
                    state_nx      = IDLE;
                end else begin
                    cnt_nx    = cnt + TO_W'(1);
                    trig_g_nx = 1'b0;
                end
            end
            XFER: begin
                if (g_dack_n) begin
                    state_nx = IDLE;
                end else if (iow_rise) begin
                    ack_nx     = 1'b1;
                    tc_nx      = tc_s;
                    rdata_load = 1'b1;
                    state_nx   = HOLD;
`ifdef ISA_DMA_RECORD_EN
                end else if (ior_rise) begin
                    ack_nx   = 1'b1;
                    tc_nx    = tc_s;
                    state_nx = HOLD;
                end else begin
                    // Single mode: DRQ drops once the bus cycle has started
                    trig_g_nx = g_trig_n | ~iow_s | ~ior_s;
                    sd_oe_nx  = ~ior_s;
`else
                end else begin
                    trig_g_nx = g_trig_n | ~iow_s;
`endif
                end
            end
            HOLD: begin
                if (g_dack_n) begin
                    last_grant_nx = grant;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b0;
            cnt           <= '0;
            drq_lo_trig_n <= 1'b1;
            drq_hi_trig_n <= 1'b1;
            ack8          <= 1'b0;
            ack16         <= 1'b0;
            tc_pulse      <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
            rdata         <= '0;
`ifdef ISA_DMA_RECORD_EN
            sd_oe         <= 1'b0;
            sd_out        <= '0;
`endif
        end else begin
            state         <= state_nx;
            grant         <= grant_nx;
            last_grant    <= last_grant_nx;
            cnt           <= cnt_nx;
            drq_lo_trig_n <= grant_nx | trig_g_nx;
            drq_hi_trig_n <= ~grant_nx | trig_g_nx;
            ack8          <= ack_nx & ~grant;
            ack16         <= ack_nx & grant;
            tc_pulse      <= tc_nx;
            timeout       <= timeout_nx;
            busy          <= (state_nx != IDLE);
            if (rdata_load) rdata <= sd_hold;
`ifdef ISA_DMA_RECORD_EN
            sd_oe         <= sd_oe_nx;
            sd_out        <= sd_oe_nx ? wdata : '0;
`endif
        end
    end

endmodule

// File: doc/isa_dma_sequencer.md
Name: isa_dma_sequencer

Overview:
- Sequences ISA single-mode DMA for the sound card and shares the two on-card DRQ trigger lines (8-bit on DRQ_LO, 16-bit on DRQ_HI) between the 8-bit and 16-bit sound DMA requesters.
- Synchronises the asynchronous ISA handshake inputs (DACKx_N, IOW_N, IOR_N, AEN, TC).
- Allows one outstanding request at a time.
- Produces a clean one-cycle ack strobe with captured bus data for the sound core.

Parameters:
- TIMEOUT_CYCLES, 4096: clk cycles to wait for DACK before withdrawing DRQ; minimum 4.
- TO_W, 12: timeout counter width; must satisfy 2^TO_W >= TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, ISA-bus-derived, nominally 8 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req8  in  1  level request from the 8-bit sound DMA engine.
- req16  in  1  level request from the 16-bit sound DMA engine.
- dack8_n  in  1  ISA DACK for the 8-bit channel, async, active-low.
- dack16_n  in  1  ISA DACK for the 16-bit channel, async, active-low.
- iow_n  in  1  ISA IOW_N, async.
- ior_n  in  1  ISA IOR_N, async.
- aen  in  1  ISA AEN, async.
- tc  in  1  ISA TC, async.
- sd_in  in  16  ISA data bus, input side.
- drq_lo_trig_n  out  1  low = assert 8-bit DRQ pin.
- drq_hi_trig_n  out  1  low = assert 16-bit DRQ pin.
- ack8  out  1  one-cycle transfer-complete strobe, 8-bit channel.
- ack16  out  1  one-cycle transfer-complete strobe, 16-bit channel.
- rdata  out  16  bus data captured for the last transfer.
- tc_pulse  out  1  one-cycle pulse, coincident with ackX, when TC was high.
- timeout  out  1  one-cycle pulse on DRQ withdrawal after timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all strobes 0, trig_n outputs 1, rdata 0, busy 0, state IDLE, last_grant=8, all synchroniser flops at inactive levels.
- Synchronisers: 2-FF on dack8_n, dack16_n, iow_n, ior_n, aen, tc (the _s signals). Edge detect compares the _s value against a third flop.
- sd_in is registered every cycle while iow_s=0; this register supplies rdata.
- States: IDLE, REQ, XFER, HOLD. grant is a 1-bit register (0 = 8-bit, 1 = 16-bit).
- IDLE:
  - Only req8 set: grant=0.
  - Only req16 set: grant=1.
  - Both set: grant the channel that is not last_grant (round robin).
  - Any request set: go to REQ and clear the timeout counter. Granted trig_n goes low on the cycle after the grant decision.
- REQ:
  - Granted trig_n held low; counter increments each cycle.
  - Granted dack_s=0 and aen_s=1: go to XFER.
  - Granted req drops before DACK: trig_n high, go to IDLE, no ack, last_grant unchanged.
  - Counter reaches TIMEOUT_CYCLES-1 with no DACK: trig_n high, timeout=1 for one cycle, go to IDLE, last_grant updated to grant so the other channel is not starved.
  - DACK on the non-granted channel is ignored.
- XFER:
  - trig_n goes high on the first cycle iow_s=0 (single mode).
  - On iow_s rising edge with granted dack_s still 0: rdata takes the held register value; ackX=1 for exactly one cycle; tc_pulse=tc_s on the same cycle. Go to HOLD.
  - Granted dack_s returns high with no IOW edge: go to IDLE, trig_n high, no ack.
- HOLD: wait for granted dack_s=1, then last_grant=grant and go to IDLE. A request still held re-arbitrates on the next cycle.
- Latency: ackX follows the ISA IOW_N rising edge by 3 clk.
- At most one of trig_n low, ack8, ack16 per channel at a time. Both trig_n outputs are never low simultaneously.
- Asynchronous reset mid-transfer: outputs go to reset values immediately, with no ack generated.

Optional Feature:
- Macro ISA_DMA_RECORD_EN adds ports wdata in 16, sd_out out 16 and sd_oe out 1.
- In XFER with granted dack_s=0 and ior_s=0: sd_oe=1 and sd_out=wdata.
- The ack strobe then fires on the ior_s rising edge instead of iow_s; rdata is unchanged in this case.
- Without the macro: ior_n only passes through its synchroniser, and no extra ports exist.

Test Plan:
- req8=1, DACK8 low after 10 clk, IOW pulse with sd_in=0x00A5 -> drq_lo_trig_n low from cycle 2; ack8 pulses once, 3 clk after the IOW rise; rdata=0x00A5; drq_hi_trig_n stays 1 throughout.
- req8 and req16 raised on the same cycle, each serviced with DACK/IOW -> grant order 16 then 8 (last_grant reset=8); both channels' trig_n never low together.
- req16=1, no DACK -> timeout pulse at cycle TIMEOUT_CYCLES; drq_hi_trig_n returns high; busy returns 0.
- req16=1 and DACK16 low, IOW pulse with tc=1 and sd_in=0x1234 -> ack16 and tc_pulse on the same cycle; rdata=0x1234.
- rst_n low while in XFER -> trig_n=1, busy=0, no ack; after release, req8 re-arbitrates normally.
- ISA_DMA_RECORD_EN with wdata=0xBEEF, DACK8 and IOR pulse -> sd_oe high while IOR is low; sd_out=0xBEEF; ack8 pulses after the IOR rise.
